// File: rtl/kuuga_mem_pkg.sv
// rtl/kuuga_mem_pkg.sv - shared constants and response record for the data-memory responder
// Contents:
//   BAD_ADDR_DATA    - read data returned for out-of-range word indices
//   BYTE_OFFSET_BITS - address bits below the word index
//   mem_resp_t       - one queued response {valid, is_write, data}
package kuuga_mem_pkg;

  localparam logic [31:0] BAD_ADDR_DATA    = 32'hDEAD_BEEF;
  localparam int          BYTE_OFFSET_BITS = 2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] data;
  } mem_resp_t;

endpackage

// File: rtl/mem_resp_pipeline.sv
// rtl/mem_resp_pipeline.sv - fixed-latency response shift register
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   in_resp   - response captured at the grant edge
//   out_resp  - response presented LATENCY cycles after its grant cycle
module mem_resp_pipeline
  import kuuga_mem_pkg::*;
#(
  parameter int LATENCY = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  mem_resp_t in_resp,
  output mem_resp_t out_resp
);

  mem_resp_t stage_q [LATENCY];
  mem_resp_t stage_d [LATENCY];

  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i];
    end
    stage_d[0] = in_resp;
    for (int i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
    // The last stage drives rdata directly, so keep its payload when an
    // empty slot arrives instead of letting the output bus churn.
    if (!stage_d[LATENCY-1].valid) begin
      stage_d[LATENCY-1].is_write = stage_q[LATENCY-1].is_write;
      stage_d[LATENCY-1].data     = stage_q[LATENCY-1].data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_resp = stage_q[LATENCY-1];

endmodule

// File: rtl/ri5cy_data_mem_responder.sv
// rtl/ri5cy_data_mem_responder.sv - word-addressed memory endpoint for the RI5CY data-request port
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   data_req_i/addr/we/be/wdata    - request (byte address, write enable, byte enables, write data)
//   stall_i                        - blocks new grants while high
//   data_gnt_o                     - combinational grant
//   data_rvalid_o, data_rdata_o    - in-order response, LATENCY cycles after grant
//   read_count/write_count/err_count - granted reads, writes, out-of-range accesses
module ri5cy_data_mem_responder
  import kuuga_mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 4096,
  parameter int LATENCY         = 2,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    data_req_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  input  logic                    stall_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic [31:0]             read_count,
  output logic [31:0]             write_count,
  output logic [31:0]             err_count
);

  localparam int IDX_W  = ADDR_WIDTH - BYTE_OFFSET_BITS;
  localparam int MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int INF_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int NB     = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IDX_W-1:0]  word_idx;
  logic [MEM_AW-1:0] mem_idx;
  logic              in_range;

  logic [INF_W-1:0]  inflight_q, inflight_d;
  logic [31:0]       read_count_q, read_count_d;
  logic [31:0]       write_count_q, write_count_d;
  logic [31:0]       err_count_q, err_count_d;

  logic              gnt;
  logic              retire_now;
  mem_resp_t         resp_in;
  mem_resp_t         resp_out;

  assign word_idx = data_addr_i[ADDR_WIDTH-1:BYTE_OFFSET_BITS];
  assign mem_idx  = word_idx[MEM_AW-1:0];
  assign in_range = 32'(word_idx) < 32'(MEM_DEPTH);

  // A retiring response frees its slot in the same cycle, so a full
  // window can still accept a new request alongside the retirement.
  assign retire_now = resp_out.valid;
  assign gnt = ~rst & data_req_i & ~stall_i &
               ((inflight_q < INF_W'(MAX_OUTSTANDING)) | retire_now);

  always_comb begin
    inflight_d    = inflight_q;
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    err_count_d   = err_count_q;
    resp_in       = '0;

    if (gnt && !retire_now) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!gnt && retire_now) begin
      inflight_d = inflight_q - 1'b1;
    end

    if (gnt) begin
      resp_in.valid    = 1'b1;
      resp_in.is_write = data_we_i;
      // Reads capture the word now, so later writes cannot disturb them.
      if (!data_we_i) begin
        resp_in.data = in_range ? mem[mem_idx] : BAD_ADDR_DATA;
      end
      if (data_we_i) begin
        write_count_d = write_count_q + 32'd1;
      end else begin
        read_count_d = read_count_q + 32'd1;
      end
      if (!in_range) begin
        err_count_d = err_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_q    <= '0;
      read_count_q  <= '0;
      write_count_q <= '0;
      err_count_q   <= '0;
    end else begin
      inflight_q    <= inflight_d;
      read_count_q  <= read_count_d;
      write_count_q <= write_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // Backing store is intentionally not reset; committed writes survive rst.
  always_ff @(posedge clk) begin
    if (gnt && data_we_i && in_range) begin
      for (int b = 0; b < NB; b++) begin
        if (data_be_i[b]) begin
          mem[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
        end
      end
    end
  end

  mem_resp_pipeline #(
    .LATENCY (LATENCY)
  ) u_resp_pipe (
    .clk      (clk),
    .rst      (rst),
    .in_resp  (resp_in),
    .out_resp (resp_out)
  );

  assign data_gnt_o    = gnt;
  assign data_rvalid_o = resp_out.valid;
  assign data_rdata_o  = resp_out.data;
  assign read_count    = read_count_q;
  assign write_count   = write_count_q;
  assign err_count     = err_count_q;

  inflight_bound_a: assert property (@(posedge clk) disable iff (rst)
    inflight_q <= INF_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_ri5cy_data_mem_responder.sv
// tb/tb_ri5cy_data_mem_responder.sv - self-checking bench for ri5cy_data_mem_responder
module tb_ri5cy_data_mem_responder;

  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;
  localparam int LAT   = 4;
  localparam int MAXO  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          data_req_i = 1'b0;
  logic [AW-1:0] data_addr_i = '0;
  logic          data_we_i = 1'b0;
  logic [3:0]    data_be_i = '0;
  logic [DW-1:0] data_wdata_i = '0;
  logic          stall_i = 1'b0;
  logic          data_gnt_o;
  logic          data_rvalid_o;
  logic [DW-1:0] data_rdata_o;
  logic [31:0]   read_count, write_count, err_count;

  always #5 clk = ~clk;

  ri5cy_data_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(DEPTH),
    .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst), .data_req_i(data_req_i), .data_addr_i(data_addr_i),
    .data_we_i(data_we_i), .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .stall_i(stall_i), .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o), .read_count(read_count), .write_count(write_count),
    .err_count(err_count)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [31:0] d; } obs_t;
  obs_t gnt_log[$];
  obs_t rsp_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (data_gnt_o)    gnt_log.push_back('{c: cyc, d: 32'h0});
      if (data_rvalid_o) rsp_log.push_back('{c: cyc, d: data_rdata_o});
    end
  end

  // Reference model: sparse word memory plus the in-order list of expected responses.
  logic [31:0] model_mem [int];
  logic [31:0] exp_q[$];
  int exp_rd = 0, exp_wr = 0, exp_err = 0;

  function automatic logic [31:0] model_word(int idx);
    return model_mem.exists(idx) ? model_mem[idx] : 32'h0;
  endfunction

  task automatic model_access(input logic we, input logic [15:0] addr,
                              input logic [3:0] be, input logic [31:0] wd);
    int idx;
    bit inr;
    logic [31:0] w;
    idx = int'(addr) / 4;
    inr = (idx < DEPTH);
    if (!inr) exp_err++;
    if (we) begin
      exp_wr++;
      if (inr) begin
        w = model_word(idx);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        model_mem[idx] = w;
      end
      exp_q.push_back(32'h0);
    end else begin
      exp_rd++;
      exp_q.push_back(inr ? model_word(idx) : 32'hDEAD_BEEF);
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_log.delete();
    exp_q.delete();
  endtask

  task automatic issue(input logic we, input logic [15:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input int stall_pct);
    int n = 0;
    bit granted = 0;
    data_req_i = 1'b1; data_we_i = we; data_addr_i = addr; data_be_i = be; data_wdata_i = wd;
    while (!granted && n < 100) begin
      stall_i = (int'($urandom_range(0, 99)) < stall_pct);
      @(negedge clk);
      if (data_gnt_o) begin
        granted = 1;
        model_access(we, addr, be, wd);
      end
      @(posedge clk); #1;
      n++;
    end
    data_req_i = 1'b0;
    stall_i = 1'b0;
    if (!granted) begin
      errors++; checks++;
      $display("FAIL issue_timeout addr=%h: no grant after %0d cycles", addr, n);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (rsp_log.size() < gnt_log.size() && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (LAT + 1) @(negedge clk);
    checks++;
    if (rsp_log.size() != gnt_log.size()) begin
      errors++;
      $display("FAIL resp_count: got %0d responses, required %0d", rsp_log.size(), gnt_log.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    data_req_i = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (data_gnt_o !== 1'b0)    begin errors++; $display("FAIL reset_gnt: got %b, required 0", data_gnt_o); end
    checks++; if (data_rvalid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b, required 0", data_rvalid_o); end
    checks++; if (data_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", data_rdata_o); end
    checks++;
    if ({read_count, write_count, err_count} !== 96'h0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d/%0d, required 0/0/0", read_count, write_count, err_count);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    data_req_i = 1'b0;
  endtask

  task automatic test_write_read();
    clear_logs();
    issue(1'b1, 16'h0010, 4'hF, 32'hA5A5_1234, 0);
    issue(1'b0, 16'h0010, 4'hF, 32'h0, 0);
    wait_idle();
    checks++; if (rsp_log[1].d !== 32'hA5A5_1234) begin errors++; $display("FAIL wr_rd_data: got %h, required a5a51234", rsp_log[1].d); end
    checks++; if (rsp_log[1].c - gnt_log[1].c !== LAT) begin errors++; $display("FAIL wr_rd_latency: got %0d, required %0d", rsp_log[1].c - gnt_log[1].c, LAT); end
    checks++; if (rsp_log[0].d !== 32'h0) begin errors++; $display("FAIL wr_resp_data: got %h, required 0", rsp_log[0].d); end
    checks++; if (read_count !== 32'd1)  begin errors++; $display("FAIL wr_rd_read_count: got %0d, required 1", read_count); end
    checks++; if (write_count !== 32'd1) begin errors++; $display("FAIL wr_rd_write_count: got %0d, required 1", write_count); end
  endtask

  task automatic test_byte_enable();
    clear_logs();
    issue(1'b1, 16'h0020, 4'hF, 32'h1122_3344, 0);
    issue(1'b1, 16'h0020, 4'b0101, 32'hFFFF_FFFF, 0);
    issue(1'b0, 16'h0022, 4'hF, 32'h0, 0);
    wait_idle();
    checks++; if (rsp_log[2].d !== 32'h11FF_33FF) begin errors++; $display("FAIL byte_enable: got %h, required 11ff33ff", rsp_log[2].d); end
    checks++; if (rsp_log[2].d !== exp_q[2]) begin errors++; $display("FAIL byte_enable_model: got %h, required %h", rsp_log[2].d, exp_q[2]); end
  endtask

  task automatic test_outstanding();
    logic [7:0] pat;
    int c0 = 0;
    int rv_off[4] = '{4, 5, 8, 9};
    clear_logs();
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 16'h0010; data_be_i = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) c0 = cyc;
      pat[i] = data_gnt_o;
      if (data_gnt_o) model_access(1'b0, 16'h0010, 4'hF, 32'h0);
      @(posedge clk); #1;
    end
    data_req_i = 1'b0;
    checks++; if (pat !== 8'b0011_0011) begin errors++; $display("FAIL outstanding_gnt: got %b, required 00110011", pat); end
    wait_idle();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rsp_log[k].c - c0 !== rv_off[k]) begin
        errors++; $display("FAIL outstanding_rvalid%0d: got cycle %0d, required %0d", k, rsp_log[k].c - c0, rv_off[k]);
      end
      checks++;
      if (rsp_log[k].d !== exp_q[k]) begin
        errors++; $display("FAIL outstanding_data%0d: got %h, required %h", k, rsp_log[k].d, exp_q[k]);
      end
    end
  endtask

  task automatic test_read_then_write();
    issue(1'b1, 16'h0040, 4'hF, 32'h0, 0);
    wait_idle();
    clear_logs();
    issue(1'b0, 16'h0040, 4'hF, 32'h0, 0);
    issue(1'b1, 16'h0040, 4'hF, 32'h7, 0);
    issue(1'b0, 16'h0040, 4'hF, 32'h0, 0);
    wait_idle();
    checks++; if (rsp_log[0].d !== 32'h0) begin errors++; $display("FAIL rtw_old_data: got %h, required 0", rsp_log[0].d); end
    checks++; if (gnt_log[1].c - gnt_log[0].c !== 1) begin errors++; $display("FAIL rtw_b2b_gnt: got gap %0d, required 1", gnt_log[1].c - gnt_log[0].c); end
    checks++; if (rsp_log[1].c - rsp_log[0].c !== 1) begin errors++; $display("FAIL rtw_b2b_rvalid: got gap %0d, required 1", rsp_log[1].c - rsp_log[0].c); end
    checks++; if (rsp_log[2].d !== 32'h7) begin errors++; $display("FAIL rtw_new_data: got %h, required 7", rsp_log[2].d); end
  endtask

  task automatic test_out_of_range();
    clear_logs();
    issue(1'b0, 16'h4000, 4'hF, 32'h0, 0);
    issue(1'b1, 16'h0004, 4'hF, 32'h5A5A_0001, 0);
    issue(1'b1, 16'h4004, 4'hF, 32'hFFFF_FFFF, 0);
    issue(1'b0, 16'h0004, 4'hF, 32'h0, 0);
    wait_idle();
    checks++; if (rsp_log[0].d !== 32'hDEAD_BEEF) begin errors++; $display("FAIL oor_read: got %h, required deadbeef", rsp_log[0].d); end
    checks++; if (rsp_log[3].d !== 32'h5A5A_0001) begin errors++; $display("FAIL oor_write_alias: got %h, required 5a5a0001", rsp_log[3].d); end
    checks++; if (err_count !== 32'(exp_err)) begin errors++; $display("FAIL oor_err_count: got %0d, required %0d", err_count, exp_err); end
    checks++; if (write_count !== 32'(exp_wr)) begin errors++; $display("FAIL oor_write_count: got %0d, required %0d", write_count, exp_wr); end
  endtask

  task automatic test_stall();
    clear_logs();
    issue(1'b0, 16'h0020, 4'hF, 32'h0, 0);
    stall_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 16'h0010;
    for (int i = 0; i < LAT + 1; i++) begin
      @(negedge clk);
      checks++; if (data_gnt_o !== 1'b0) begin errors++; $display("FAIL stall_gnt%0d: got %b, required 0", i, data_gnt_o); end
      @(posedge clk); #1;
    end
    checks++; if (rsp_log.size() !== 1) begin errors++; $display("FAIL stall_inflight_done: got %0d responses, required 1", rsp_log.size()); end
    checks++; if (rsp_log[0].c - gnt_log[0].c !== LAT) begin errors++; $display("FAIL stall_latency: got %0d, required %0d", rsp_log[0].c - gnt_log[0].c, LAT); end
    issue(1'b0, 16'h0010, 4'hF, 32'h0, 0);
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      checks++; if (rsp_log[k].d !== exp_q[k]) begin errors++; $display("FAIL stall_data%0d: got %h, required %h", k, rsp_log[k].d, exp_q[k]); end
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    clear_logs();
    issue(1'b0, 16'h0010, 4'hF, 32'h0, 0);
    rst = 1'b1;
    data_req_i = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_gnt_o, data_rvalid_o, data_rdata_o, read_count, write_count, err_count} !== 130'h0) begin
      errors++;
      $display("FAIL midreset_outputs: gnt=%b rvalid=%b rdata=%h counts=%0d/%0d/%0d, required all 0",
               data_gnt_o, data_rvalid_o, data_rdata_o, read_count, write_count, err_count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    data_req_i = 1'b0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (data_rvalid_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_dropped: got %0d rvalid, required 0", seen); end
    @(posedge clk); #1;
    clear_logs();
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    issue(1'b0, 16'h0010, 4'hF, 32'h0, 0);
    wait_idle();
    checks++; if (rsp_log[0].d !== 32'hA5A5_1234) begin errors++; $display("FAIL midreset_fresh_data: got %h, required a5a51234", rsp_log[0].d); end
    checks++; if (rsp_log[0].c - gnt_log[0].c !== LAT) begin errors++; $display("FAIL midreset_fresh_latency: got %0d, required %0d", rsp_log[0].c - gnt_log[0].c, LAT); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic        we;
    clear_logs();
    for (int k = 0; k < 16; k++) issue(1'b1, 16'h0100 + 16'(4 * k), 4'hF, $urandom, 0);
    for (int t = 0; t < 60; t++) begin
      we = 1'($urandom_range(0, 1));
      a  = 16'h0100 + 16'(4 * $urandom_range(0, 15)) + 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 16'h4000;
      issue(we, a, 4'($urandom), $urandom, 30);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    wait_idle();
    for (int k = 0; k < exp_q.size(); k++) begin
      checks++;
      if (rsp_log[k].d !== exp_q[k]) begin
        errors++; $display("FAIL random_data%0d: got %h, required %h", k, rsp_log[k].d, exp_q[k]);
      end
      checks++;
      if (rsp_log[k].c - gnt_log[k].c !== LAT) begin
        errors++; $display("FAIL random_latency%0d: got %0d, required %0d", k, rsp_log[k].c - gnt_log[k].c, LAT);
      end
    end
    checks++; if (read_count !== 32'(exp_rd))  begin errors++; $display("FAIL random_read_count: got %0d, required %0d", read_count, exp_rd); end
    checks++; if (write_count !== 32'(exp_wr)) begin errors++; $display("FAIL random_write_count: got %0d, required %0d", write_count, exp_wr); end
    checks++; if (err_count !== 32'(exp_err))  begin errors++; $display("FAIL random_err_count: got %0d, required %0d", err_count, exp_err); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_enable();
    test_outstanding();
    test_read_then_write();
    test_out_of_range();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
